// File: rtl/alu_packet_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// alu_packet_deserializer_pkg
//  Shared types for the ALU side of the mini serial processor link.
//  Holds the ALU operation codes, the packet layout that the deserializer
//  assembles, the frame width derived from it, and the receiver state type.
//  Packet layout (MSB..LSB): {op_2[31:0], op_1[31:0], op_code[2:0]}.
//  op_code sits in the least significant bits, so it is the first field on
//  the wire.
// ---------------------------------------------------------------------------
package alu_packet_deserializer_pkg;

   typedef enum logic [2:0] {
      ADD = 3'h0,
      SUB = 3'h1,
      XOR = 3'h2,
      MUL = 3'h3,
      SHL = 3'h4,
      SHR = 3'h5,
      LW  = 3'h6,
      SW  = 3'h7
   } Operation;

   typedef struct packed {
      logic [31:0] op_2;
      logic [31:0] op_1;
      Operation    op_code;
   } AluPacket;

   localparam int ALU_PACKET_WIDTH = $bits(AluPacket);
   localparam int ALU_COUNT_WIDTH  = $clog2(ALU_PACKET_WIDTH + 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_RECV,
      RX_FULL
   } AluRxState;

endpackage

// File: rtl/serial_shift_register.sv
// ---------------------------------------------------------------------------
// serial_shift_register
//  Right-shifting serial-to-parallel register. Each shift inserts bit_in at
//  the MSB, so after WIDTH shifts the first bit received sits in bit 0.
//  Reusable by any of the link receivers (ALU, MUL, shifter packets).
//
// Ports
//  clock_i     in   1      rising-edge clock
//  reset_i     in   1      asynchronous active-high reset, clears contents
//  shift_en_i  in   1      shift bit_in_i in this cycle
//  clear_i     in   1      zero the register; combined with shift_en_i the
//                          new bit lands in a cleared register
//  bit_in_i    in   1      serial data bit
//  data_o      out  WIDTH  current register contents
// ---------------------------------------------------------------------------
module serial_shift_register #(
   parameter int WIDTH = 8
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             shift_en_i,
   input  logic             clear_i,
   input  logic             bit_in_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] base;

   always_comb begin
      base   = clear_i ? '0 : data_q;
      data_d = base;
      if (shift_en_i) begin
         data_d = {bit_in_i, base[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/alu_packet_deserializer.sv
// ---------------------------------------------------------------------------
// alu_packet_deserializer
//  ALU-side receiver of the mini serial processor link. Collects one framed
//  serial stream (op_code first, every field LSB first) into an AluPacket and
//  hands it to the ALU with a valid/ready handshake. The link is held off
//  (rx_ready_o low) while a completed packet waits to be consumed.
//
// Ports
//  clock_i         in   1             rising-edge clock
//  reset_i         in   1             asynchronous active-high reset
//  rx_bit_i        in   1             serial data bit
//  rx_valid_i      in   1             rx_bit_i valid; taken when rx_ready_o=1
//  rx_sof_i        in   1             marks the first bit of a frame
//  rx_ready_o      out  1             receiver can take a bit
//  packet_out_o    out  PACKET_WIDTH  assembled packet, stable while valid
//  packet_valid_o  out  1             packet_out_o holds a complete frame
//  packet_ready_i  in   1             ALU takes the packet
//  frame_error_o   out  1             one-cycle pulse per framing violation
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RX_IDLE | waiting for a start-of-frame bit; stray bits flag an error
// RX_RECV | frame in progress, bit_count_q bits already captured
// RX_FULL | complete packet presented to the ALU, link back-pressured
// ---------------------------------------------------------------------------
module alu_packet_deserializer
   import alu_packet_deserializer_pkg::*;
#(
   parameter int PACKET_WIDTH = ALU_PACKET_WIDTH
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    rx_bit_i,
   input  logic                    rx_valid_i,
   input  logic                    rx_sof_i,
   output logic                    rx_ready_o,
   output logic [PACKET_WIDTH-1:0] packet_out_o,
   output logic                    packet_valid_o,
   input  logic                    packet_ready_i,
   output logic                    frame_error_o
);

   localparam int CW = $clog2(PACKET_WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(PACKET_WIDTH - 1);

   AluRxState         state_q;
   AluRxState         state_d;
   logic [CW-1:0]     bit_count_q;
   logic [CW-1:0]     bit_count_d;
   logic              frame_error_q;
   logic              frame_error_d;
   logic              shift_en;
   logic              sr_clear;
   logic              accept;
   logic [PACKET_WIDTH-1:0] sr_data;

   assign rx_ready_o = (state_q != RX_FULL);
   assign accept     = rx_valid_i && rx_ready_o;

   always_comb begin
      state_d       = state_q;
      bit_count_d   = bit_count_q;
      frame_error_d = 1'b0;
      shift_en      = 1'b0;
      sr_clear      = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            if (accept) begin
               if (rx_sof_i) begin
                  shift_en    = 1'b1;
                  sr_clear    = 1'b1;
                  bit_count_d = CW'(1);
                  state_d     = RX_RECV;
               end else begin
                  frame_error_d = 1'b1;
               end
            end
         end
         RX_RECV: begin
            if (accept) begin
               shift_en = 1'b1;
               if (rx_sof_i) begin
                  // New frame starts over the partial one; the sof bit is
                  // kept as bit 0 of the restarted frame.
                  frame_error_d = 1'b1;
                  sr_clear      = 1'b1;
                  bit_count_d   = CW'(1);
               end else if (bit_count_q == LAST_BIT) begin
                  bit_count_d = '0;
                  state_d     = RX_FULL;
               end else begin
                  bit_count_d = bit_count_q + CW'(1);
               end
            end
         end
         RX_FULL: begin
            if (packet_ready_i) begin
               state_d = RX_IDLE;
            end
         end
         default: begin
            state_d     = RX_IDLE;
            bit_count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= RX_IDLE;
         bit_count_q   <= '0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_count_q   <= bit_count_d;
         frame_error_q <= frame_error_d;
      end
   end

   // The shift register does not move in RX_FULL, so its contents serve
   // directly as the held packet.
   serial_shift_register #(
      .WIDTH(PACKET_WIDTH)
   ) u_sr (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .shift_en_i (shift_en),
      .clear_i    (sr_clear),
      .bit_in_i   (rx_bit_i),
      .data_o     (sr_data)
   );

   assign packet_out_o   = sr_data;
   assign packet_valid_o = (state_q == RX_FULL);
   assign frame_error_o  = frame_error_q;

endmodule

// File: tb/tb_alu_packet_deserializer.sv
module tb_alu_packet_deserializer;
   import alu_packet_deserializer_pkg::*;

   localparam int W = ALU_PACKET_WIDTH;

   logic          clock = 1'b0;
   logic          reset;
   logic          rx_bit;
   logic          rx_valid;
   logic          rx_sof;
   logic          rx_ready;
   logic [W-1:0]  packet_out;
   logic          packet_valid;
   logic          packet_ready;
   logic          frame_error;

   int n_checks = 0;
   int n_fail   = 0;
   int err_cnt  = 0;

   logic [W-1:0] sb_q[$];
   logic [W-1:0] mon_exp;

   always #5 clock = ~clock;

   alu_packet_deserializer dut (
      .clock_i        (clock),
      .reset_i        (reset),
      .rx_bit_i       (rx_bit),
      .rx_valid_i     (rx_valid),
      .rx_sof_i       (rx_sof),
      .rx_ready_o     (rx_ready),
      .packet_out_o   (packet_out),
      .packet_valid_o (packet_valid),
      .packet_ready_i (packet_ready),
      .frame_error_o  (frame_error)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      AluPacket p;
      p.op_code = Operation'(op);
      p.op_1    = a;
      p.op_2    = b;
      return p;
   endfunction

   // Scoreboard side: every handshake pops one expected packet.
   always @(negedge clock) begin
      if (!reset) begin
         if (frame_error) err_cnt++;
         if (packet_valid && packet_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected", W'(1), W'(0));
            end else begin
               mon_exp = sb_q.pop_front();
               chk("sb_packet", packet_out, mon_exp);
            end
         end
      end
   end

   task automatic send_bit(input logic b, input logic sof);
      int waited = 0;
      rx_bit   = b;
      rx_valid = 1'b1;
      rx_sof   = sof;
      @(negedge clock);
      while (!rx_ready && waited < 200) begin
         waited++;
         @(negedge clock);
      end
      if (!rx_ready) chk("send_timeout", W'(0), W'(1));
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
   endtask

   task automatic send_partial(input logic [W-1:0] pkt, input int n);
      for (int i = 0; i < n; i++) send_bit(pkt[i], i == 0);
   endtask

   task automatic send_frame(input logic [W-1:0] pkt, input bit gaps);
      sb_q.push_back(pkt);
      for (int i = 0; i < W; i++) begin
         if (gaps) begin
            rx_bit = 1'($urandom);
            repeat ($urandom_range(1, 5)) @(posedge clock);
            #1;
         end
         send_bit(pkt[i], i == 0);
      end
   endtask

   task automatic drain();
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      AluPacket     p;
      logic [W-1:0] pk;
      int           e0;

      reset        = 1'b1;
      rx_bit       = 1'b0;
      rx_valid     = 1'b0;
      rx_sof       = 1'b0;
      packet_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_rx_ready",    W'(rx_ready),     W'(1));
      chk("rst_valid",       W'(packet_valid), W'(0));
      chk("rst_frame_error", W'(frame_error),  W'(0));
      chk("rst_packet_out",  packet_out,       W'(0));
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // 1: ADD frame, continuous valid
      e0 = err_cnt;
      send_frame(mk(3'h0, 32'h0000_0005, 32'h0000_0003), 1'b0);
      @(negedge clock);
      chk("t1_valid_latency", W'(packet_valid), W'(1));
      p = packet_out;
      chk("t1_op_code", W'(p.op_code), W'(3'h0));
      chk("t1_op_1",    W'(p.op_1),    W'(32'h5));
      chk("t1_op_2",    W'(p.op_2),    W'(32'h3));
      @(posedge clock);
      #1;
      chk("t1_idle_after", W'(packet_valid), W'(0));
      chk("t1_no_error",   W'(err_cnt - e0), W'(0));

      // 2: SW frame with ALU stalled
      packet_ready = 1'b0;
      pk = mk(3'h7, 32'hDEAD_BEEF, 32'h8000_0001);
      e0 = err_cnt;
      send_frame(pk, 1'b0);
      for (int c = 0; c < 10; c++) begin
         rx_valid = 1'b1;
         rx_bit   = 1'($urandom);
         rx_sof   = (c == 3);
         @(negedge clock);
         chk("t2_stable",   packet_out,       pk);
         chk("t2_rx_ready", W'(rx_ready),     W'(0));
         chk("t2_valid",    W'(packet_valid), W'(1));
         @(posedge clock);
         #1;
      end
      rx_valid     = 1'b0;
      rx_sof       = 1'b0;
      packet_ready = 1'b1;
      @(posedge clock);
      #1;
      chk("t2_release_valid", W'(packet_valid), W'(0));
      chk("t2_release_ready", W'(rx_ready),     W'(1));
      chk("t2_no_error",      W'(err_cnt - e0), W'(0));

      // 3: sof reasserted at bit 20, then full MUL frame
      e0 = err_cnt;
      send_partial(mk(3'h2, 32'h1234_5678, 32'h9ABC_DEF0), 20);
      send_frame(mk(3'h3, 32'h7, 32'h6), 1'b0);
      drain();
      chk("t3_one_error", W'(err_cnt - e0), W'(1));

      // 4: SHL gap-free then with random gaps, same expected packet
      e0 = err_cnt;
      send_frame(mk(3'h4, 32'h1, 32'h1F), 1'b0);
      drain();
      send_frame(mk(3'h4, 32'h1, 32'h1F), 1'b1);
      drain();
      chk("t4_no_error", W'(err_cnt - e0), W'(0));

      // 5: reset mid-frame at bit 40
      send_partial(mk(3'h5, 32'hFFFF_FFFF, 32'hA5A5_A5A5), 40);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_rst_valid",  W'(packet_valid), W'(0));
      chk("t5_rst_ready",  W'(rx_ready),     W'(1));
      chk("t5_rst_err",    W'(frame_error),  W'(0));
      chk("t5_rst_packet", packet_out,       W'(0));
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      send_frame(mk(3'h1, 32'hCAFE_0001, 32'h0BAD_F00D), 1'b0);
      drain();

      // 6: three stray bits in IDLE
      e0       = err_cnt;
      rx_valid = 1'b1;
      rx_sof   = 1'b0;
      rx_bit   = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      rx_valid = 1'b0;
      drain();
      chk("t6_three_errors", W'(err_cnt - e0), W'(3));
      chk("t6_valid",        W'(packet_valid), W'(0));
      chk("t6_ready",        W'(rx_ready),     W'(1));
      e0 = err_cnt;
      send_frame(mk(3'h6, 32'h0000_0100, 32'h0000_0004), 1'b0);
      drain();
      chk("t6_clean_frame", W'(err_cnt - e0), W'(0));

      chk("sb_empty", W'(sb_q.size()), W'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
